// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and pipeline-advance control for an in-order core.
// Tracks in-flight register writers from execute (stage 1) to writeback (stage DEPTH).
module pipe_hazard_ctrl #(
  parameter  int DEPTH      = 2,
  parameter  int LOAD_STAGE = 2,
  parameter  int CNT_W      = 32,
  localparam int FW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             x_redirect,
  input  logic             mem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             issue,
  output logic             load_use_stall,
  output logic [FW-1:0]    x_fwd_rs1,
  output logic [FW-1:0]    x_fwd_rs2,
  output logic             id_byp_rs1,
  output logic             id_byp_rs2,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
  } entry_t;

  entry_t entry_q [1:DEPTH];
  entry_t entry_d [1:DEPTH];

  // Source operands are only consulted while the instruction sits in stage 1.
  logic [4:0] x_rs1_q, x_rs1_d, x_rs2_q, x_rs2_d;
  logic       x_use_rs1_q, x_use_rs1_d, x_use_rs2_q, x_use_rs2_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [DEPTH:1] wr_ok, m_id1, m_id2, m_x1, m_x2;
  logic           haz1, haz2, hazard;
  logic [FW-1:0]  fwd1, fwd2;
  logic           advance, insert, stall_inc, flush_inc;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_match
      assign wr_ok[gi] = entry_q[gi].valid & entry_q[gi].wen & (entry_q[gi].rd != 5'd0);
      assign m_id1[gi] = wr_ok[gi] & (entry_q[gi].rd == id_rs1);
      assign m_id2[gi] = wr_ok[gi] & (entry_q[gi].rd == id_rs2);
      assign m_x1[gi]  = wr_ok[gi] & (entry_q[gi].rd == x_rs1_q);
      assign m_x2[gi]  = wr_ok[gi] & (entry_q[gi].rd == x_rs2_q);
    end
  endgenerate

  // Scanning oldest to youngest lets the youngest matching writer decide.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (m_id1[k]) haz1 = entry_q[k].is_load && ((k + 1) < LOAD_STAGE);
      if (m_id2[k]) haz2 = entry_q[k].is_load && ((k + 1) < LOAD_STAGE);
    end
    hazard = id_valid && ((id_use_rs1 && haz1) || (id_use_rs2 && haz2));
  end

  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    for (int k = DEPTH; k >= 2; k--) begin
      if (m_x1[k]) fwd1 = FW'(k);
      if (m_x2[k]) fwd2 = FW'(k);
    end
  end

  always_comb begin
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    ifid_flush     = 1'b0;
    issue          = 1'b0;
    load_use_stall = 1'b0;
    advance        = 1'b0;
    insert         = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze: a pending redirect stays with the frozen stage 1 until released.
    end else if (x_redirect) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      advance    = 1'b1;
      flush_inc  = 1'b1;
    end else if (hazard) begin
      load_use_stall = 1'b1;
      advance        = 1'b1;
      stall_inc      = 1'b1;
    end else begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      issue   = id_valid;
      advance = 1'b1;
      insert  = id_valid;
    end
  end

  always_comb begin
    for (int k = 1; k <= DEPTH; k++) entry_d[k] = entry_q[k];
    x_rs1_d     = x_rs1_q;
    x_rs2_d     = x_rs2_q;
    x_use_rs1_d = x_use_rs1_q;
    x_use_rs2_d = x_use_rs2_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (advance) begin
      for (int k = DEPTH; k >= 2; k--) entry_d[k] = entry_q[k-1];
      entry_d[1]  = '0;
      x_rs1_d     = 5'd0;
      x_rs2_d     = 5'd0;
      x_use_rs1_d = 1'b0;
      x_use_rs2_d = 1'b0;
      if (insert) begin
        entry_d[1]  = '{valid: 1'b1, rd: id_rd, wen: id_wen, is_load: id_is_load};
        x_rs1_d     = id_rs1;
        x_rs2_d     = id_rs2;
        x_use_rs1_d = id_use_rs1;
        x_use_rs2_d = id_use_rs2;
      end
    end
    if (stall_inc) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) entry_d[k] = '0;
      x_rs1_d     = 5'd0;
      x_rs2_d     = 5'd0;
      x_use_rs1_d = 1'b0;
      x_use_rs2_d = 1'b0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k <= DEPTH; k++) entry_q[k] <= entry_d[k];
    x_rs1_q     <= x_rs1_d;
    x_rs2_q     <= x_rs2_d;
    x_use_rs1_q <= x_use_rs1_d;
    x_use_rs2_q <= x_use_rs2_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign x_fwd_rs1  = (!reset && entry_q[1].valid && x_use_rs1_q) ? fwd1 : '0;
  assign x_fwd_rs2  = (!reset && entry_q[1].valid && x_use_rs2_q) ? fwd2 : '0;
  assign id_byp_rs1 = !reset && id_use_rs1 && m_id1[DEPTH];
  assign id_byp_rs2 = !reset && id_use_rs2 && m_id2[DEPTH];
  assign wb_valid   = !reset && !mem_stall && entry_q[DEPTH].valid && entry_q[DEPTH].wen;
  assign wb_rd      = reset ? 5'd0 : entry_q[DEPTH].rd;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
